// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared state type, default parameters and the Galois step for the LFSR sequencer
package lfsr_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DEF_WIDTH = 4;
   localparam logic [DEF_WIDTH-1:0] DEF_TAPS = 4'b0011;
   localparam int DEF_CW = 8;

   // Galois step on a right-aligned w-bit value: shift left and fold in the taps when the MSB falls off
   function automatic logic [31:0] lfsr_next(input logic [31:0] q, input logic [31:0] taps, input int w);
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return ((q << 1) ^ (q[5'(w - 1)] ? taps : 32'd0)) & mask;
   endfunction

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: loadable Galois LFSR register; load wins over step, reset clears to zero
import lfsr_ctrl_pkg::*;

module lfsr_galois #(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             step,
   output logic [WIDTH-1:0] q
);

   // LFSR state: load a fresh seed, otherwise advance one position per step
   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= load_value;
      else if (step)
         q <= WIDTH'(lfsr_next(32'(q), 32'(TAPS), WIDTH));
   end

endmodule

// File: rtl/lfsr_seq_controller.sv
// lfsr_seq_controller: accepts (seed, count) commands and streams count LFSR words over a backpressured port
import lfsr_ctrl_pkg::*;

module lfsr_seq_controller #(
   parameter int WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
   parameter int CW = DEF_CW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic [CW-1:0]    cmd_count,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_wrap,
   output logic             done,
   output logic             done_aborted,
   output logic             err_zero_seed
);

   state_t           state;
   logic [CW-1:0]    remaining;
   logic [WIDTH-1:0] seed;
   logic             first;
   logic             hs;
   logic             load;
   logic [WIDTH-1:0] q;

   assign hs        = out_valid && out_ready;
   assign load      = (state == IDLE) && cmd_valid && (cmd_seed != '0) && (cmd_count != '0);
   assign cmd_ready = (state == IDLE);
   assign out_valid = (state == RUN);
   assign done      = (state == DONE);
   assign out_data  = q;
   assign out_last  = out_valid && (remaining == CW'(1));
   assign out_wrap  = out_valid && (q == seed) && !first;

   lfsr_galois #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (cmd_seed),
      .step       (hs),
      .q          (q)
   );

   // Command FSM with word counter, seed copy and first-word flag; done qualifiers live for the DONE cycle only
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         remaining     <= '0;
         seed          <= '0;
         first         <= 1'b0;
         done_aborted  <= 1'b0;
         err_zero_seed <= 1'b0;
      end else begin
         done_aborted  <= 1'b0;
         err_zero_seed <= 1'b0;
         case (state)
            IDLE: if (cmd_valid) begin
               seed          <= cmd_seed;
               remaining     <= cmd_count;
               first         <= 1'b1;
               err_zero_seed <= (cmd_seed == '0);
               state         <= (cmd_seed == '0 || cmd_count == '0) ? DONE : RUN;
            end
            RUN: begin
               if (hs) begin
                  remaining <= remaining - CW'(1);
                  first     <= 1'b0;
               end
               if (abort) begin
                  state        <= DONE;
                  done_aborted <= 1'b1;
               end else if (hs && remaining == CW'(1))
                  state <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_seq_controller.sv
// tb_lfsr_seq_controller: scoreboard bench with a table-driven reference of the 15-word LFSR period
module tb_lfsr_seq_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_seed = '0;
   logic [7:0] cmd_count = '0;
   logic       abort = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       out_last;
   logic       out_wrap;
   logic       done;
   logic       done_aborted;
   logic       err_zero_seed;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [3:0] d;
      logic       l;
      logic       w;
   } word_t;

   word_t      wq[$];
   logic [1:0] dq[$];
   logic [3:0] seq [15] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd6, 4'd12, 4'd11,
                            4'd5, 4'd10, 4'd7, 4'd14, 4'd15, 4'd13, 4'd9};

   logic  pv = 1'b0;
   logic  pr = 1'b0;
   word_t pw = '0;

   always #5 clk = ~clk;

   lfsr_seq_controller #(.WIDTH(4), .TAPS(4'b0011), .CW(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_seed      (cmd_seed),
      .cmd_count     (cmd_count),
      .abort         (abort),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .out_wrap      (out_wrap),
      .done          (done),
      .done_aborted  (done_aborted),
      .err_zero_seed (err_zero_seed)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every handshake and every done pulse, and checks stall stability
   always @(negedge clk) begin
      if (!reset) begin
         if (pv && !pr && out_valid) begin
            chk("stall_data", out_data, pw.d);
            chk("stall_last", out_last, pw.l);
            chk("stall_wrap", out_wrap, pw.w);
         end
         if (out_valid && out_ready) begin
            chk("word_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               chk("word_data", out_data, wq[0].d);
               chk("word_last", out_last, wq[0].l);
               chk("word_wrap", out_wrap, wq[0].w);
               void'(wq.pop_front());
            end
         end
         if (done) begin
            chk("done_expected", int'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
               chk("done_aborted", done_aborted, dq[0][1]);
               chk("err_zero_seed", err_zero_seed, dq[0][0]);
               void'(dq.pop_front());
            end
         end
      end
      pv <= out_valid && !reset;
      pr <= out_ready;
      pw <= {out_data, out_last, out_wrap};
   end

   task automatic check_reset();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_wrap", out_wrap, 0);
      chk("rst_done", done, 0);
      chk("rst_done_aborted", done_aborted, 0);
      chk("rst_err_zero_seed", err_zero_seed, 0);
   endtask

   // one command: reference words come from the period table, indexed from the seed's position
   task automatic run_cmd(input logic [3:0] s, input logic [7:0] k, input int abort_at,
                          input int rmode, input int reset_after);
      int   p, n, expd, hs, got;
      logic aborted;
      p = 0;
      for (int j = 0; j < 15; j++)
         if (seq[j] == s) p = j;
      aborted = (s != 0) && (k != 0) && (abort_at >= 0) && (abort_at < int'(k));
      n = (s == 0 || k == 0) ? 0 : aborted ? abort_at + 1 : int'(k);
      expd = (s == 0 || k == 0) ? 0 : aborted ? abort_at + 1 : int'(k);
      for (int j = 0; j < n; j++)
         wq.push_back({seq[(p + j) % 15], 1'(j == int'(k) - 1), 1'(j > 0 && j % 15 == 0)});
      dq.push_back({aborted, 1'(s == 0)});
      cmd_seed = s;
      cmd_count = k;
      cmd_valid = 1'b1;
      abort = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      chk("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      hs = 0;
      got = -1;
      for (int i = 0; i < 400; i++) begin
         out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(i % 3 == 0) : 1'($urandom % 2);
         abort = (abort_at >= 0) && (hs == abort_at) && out_valid;
         if (abort) out_ready = 1'b1;
         if (reset_after >= 0 && hs == reset_after) begin
            reset = 1'b1;
            out_ready = 1'b0;
            abort = 1'b0;
         end
         @(negedge clk);
         if (reset) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            wq.delete();
            dq.delete();
            check_reset();
            repeat (3) @(posedge clk);
            #1;
            return;
         end
         if (done) begin
            got = i;
            break;
         end
         if (out_valid && out_ready) hs++;
         @(posedge clk);
         #1;
      end
      abort = 1'b0;
      chk("done_seen", int'(got >= 0), 1);
      if (got >= 0) begin
         if (rmode == 0) chk("done_latency", got, expd);
         chk("no_valid_with_done", out_valid, 0);
         @(posedge clk);
         #1;
         chk("cmd_ready_after_done", cmd_ready, 1);
      end else begin
         reset = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b0;
         wq.delete();
         dq.delete();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_reset();
      run_cmd(4'b0001, 8'd16, -1, 0, -1);
      run_cmd(4'b1011, 8'd5, -1, 1, -1);
      run_cmd(4'b0000, 8'd7, -1, 0, -1);
      run_cmd(4'b0100, 8'd0, -1, 0, -1);
      run_cmd(4'b0001, 8'd10, 2, 0, -1);
      run_cmd(4'b0110, 8'd3, -1, 0, -1);
      run_cmd(4'b0001, 8'd10, -1, 0, 4);
      run_cmd(4'b1000, 8'd2, -1, 0, -1);
      run_cmd(4'b1001, 8'd40, -1, 2, -1);
      for (int t = 0; t < 40; t++) begin
         logic [3:0] s;
         logic [7:0] k;
         int         ab;
         s = ($urandom % 8 == 0) ? 4'd0 : 4'(1 + $urandom % 15);
         k = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom % 40);
         ab = ($urandom % 3 == 0) ? int'($urandom % (32'(k) + 2)) : -1;
         run_cmd(s, k, ab, int'($urandom % 3), -1);
      end
      repeat (2) @(posedge clk);
      chk("queues_empty", wq.size() + dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
